// File: rtl/hsv_core_mem_io.sv
// Slow-path memory back end: runs one single-beat AXI4 read or write per request
// (used for I/O space) and returns a commit record.

package hsv_core_mem_io_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CAUSE_W    = 5;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1 = 3'd0,
        AXI_SIZE_2 = 3'd1,
        AXI_SIZE_4 = 3'd2
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'd0,
        AXI_RESP_EXOKAY = 2'd1,
        AXI_RESP_SLVERR = 2'd2,
        AXI_RESP_DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic [1:0] {
        COMMIT_NEXT      = 2'd0,
        COMMIT_JUMP      = 2'd1,
        COMMIT_EXCEPTION = 2'd2
    } commit_action_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_increment;
        logic [REG_ADDR_W-1:0] rd;
    } common_t;

    typedef struct packed {
        common_t   common;
        mem_size_t size;
        logic      sign_extend;
        logic      is_write;
    } mem_data_t;

    typedef struct packed {
        mem_data_t       mem_data;
        logic [XLEN-1:0] address;
        logic [XLEN-1:0] write_data;
        logic [3:0]      write_strobe;
        logic [1:0]      read_shift;
        logic            unaligned_address;
        logic            is_memory;
    } read_write_t;

    typedef struct packed {
        common_t              common;
        logic [XLEN-1:0]      next_pc;
        logic                 jump;
        logic                 trap;
        commit_action_t       action;
        logic [CAUSE_W-1:0]   trap_cause;
        logic [XLEN-1:0]      trap_value;
        logic                 writeback;
        logic [XLEN-1:0]      result;
    } commit_data_t;

    function automatic logic is_axi_error(input axi_resp_t resp);
        return resp[1];
    endfunction

endpackage

module hsv_core_mem_io
    import hsv_core_mem_io_pkg::*;
#(
    parameter int unsigned LoadMisalignCause  = 4,
    parameter int unsigned LoadFaultCause     = 5,
    parameter int unsigned StoreMisalignCause = 6,
    parameter int unsigned StoreFaultCause    = 7
) (
    input  logic                clk_core,
    input  logic                rst_core,
    input  logic                flush_req,

    input  logic                in_valid,
    output logic                in_ready,
    input  read_write_t         in,

    output logic                out_valid,
    input  logic                out_ready,
    output commit_data_t        out,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [XLEN-1:0]     m_araddr,
    output logic [2:0]          m_arsize,

    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [XLEN-1:0]     m_rdata,
    input  logic [1:0]          m_rresp,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [XLEN-1:0]     m_awaddr,
    output logic [2:0]          m_awsize,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [XLEN-1:0]     m_wdata,
    output logic [3:0]          m_wstrb,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    state_t       state_q, state_d;
    read_write_t  req_q, req_d;
    axi_size_t    axsize_q, axsize_d;
    logic         discard_q, discard_d;
    logic         arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, out_valid_d;
    commit_data_t out_d;
    logic         accept;
    logic         unused_is_memory;

    function automatic axi_size_t to_axi_size(input mem_size_t size);
        case (size)
            MEM_BYTE: return AXI_SIZE_1;
            MEM_HALF: return AXI_SIZE_2;
            default:  return AXI_SIZE_4;
        endcase
    endfunction

    // Commit record from the request plus the bus response (zero/OKAY when no bus access).
    function automatic commit_data_t build_out(
        input mem_data_t       md,
        input logic [XLEN-1:0] address,
        input logic [1:0]      read_shift,
        input logic            unaligned,
        input logic [XLEN-1:0] rdata,
        input logic            bus_err
    );
        commit_data_t    o;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] value;
        logic            trap;
        sh = rdata >> {read_shift, 3'b000};
        case (md.size)
            MEM_BYTE: value = {{24{md.sign_extend & sh[7]}}, sh[7:0]};
            MEM_HALF: value = {{16{md.sign_extend & sh[15]}}, sh[15:0]};
            default:  value = sh;
        endcase
        trap         = unaligned | bus_err;
        o.common     = md.common;
        o.next_pc    = md.common.pc_increment;
        o.jump       = 1'b0;
        o.trap       = trap;
        o.action     = trap ? COMMIT_EXCEPTION : COMMIT_NEXT;
        if (unaligned) begin
            o.trap_cause = md.is_write ? CAUSE_W'(StoreMisalignCause) : CAUSE_W'(LoadMisalignCause);
        end else begin
            o.trap_cause = md.is_write ? CAUSE_W'(StoreFaultCause) : CAUSE_W'(LoadFaultCause);
        end
        o.trap_value = address;
        o.writeback  = ~md.is_write & ~trap;
        o.result     = o.writeback ? value : '0;
        return o;
    endfunction

    assign in_ready = (state_q == ST_IDLE) & ~flush_req;
    assign accept   = in_valid & in_ready;

    assign m_araddr = req_q.address;
    assign m_awaddr = req_q.address;
    assign m_arsize = axsize_q;
    assign m_awsize = axsize_q;
    assign m_wdata  = req_q.write_data;
    assign m_wstrb  = req_q.write_strobe;

    // Routing is decided upstream; this unit executes whatever it is handed.
    assign unused_is_memory = req_q.is_memory;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        axsize_d    = axsize_q;
        discard_d   = discard_q;
        arvalid_d   = m_arvalid;
        rready_d    = m_rready;
        awvalid_d   = m_awvalid;
        wvalid_d    = m_wvalid;
        bready_d    = m_bready;
        out_valid_d = out_valid;
        out_d       = out;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d    = in;
                    axsize_d = to_axi_size(in.mem_data.size);
                    if (in.unaligned_address) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_d       = build_out(in.mem_data, in.address, in.read_shift,
                                                1'b1, '0, 1'b0);
                    end else if (in.mem_data.is_write) begin
                        state_d   = ST_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (flush_req) discard_d = 1'b1;
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (flush_req) discard_d = 1'b1;
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    if (discard_q | flush_req) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_d       = build_out(req_q.mem_data, req_q.address, req_q.read_shift,
                                                1'b0, m_rdata, is_axi_error(axi_resp_t'(m_rresp)));
                    end
                end
            end
            ST_AW_W: begin
                if (flush_req) discard_d = 1'b1;
                // Address and data channels complete independently, in any order.
                awvalid_d = m_awvalid & ~m_awready;
                wvalid_d  = m_wvalid & ~m_wready;
                if (~awvalid_d & ~wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (flush_req) discard_d = 1'b1;
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    if (discard_q | flush_req) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_d       = build_out(req_q.mem_data, req_q.address, req_q.read_shift,
                                                1'b0, '0, is_axi_error(axi_resp_t'(m_bresp)));
                    end
                end
            end
            ST_OUT: begin
                if (out_ready | flush_req) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                out_valid_d = 1'b0;
                discard_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            axsize_q  <= AXI_SIZE_1;
            discard_q <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            axsize_q  <= axsize_d;
            discard_q <= discard_d;
            m_arvalid <= arvalid_d;
            m_rready  <= rready_d;
            m_awvalid <= awvalid_d;
            m_wvalid  <= wvalid_d;
            m_bready  <= bready_d;
            out_valid <= out_valid_d;
            out       <= out_d;
        end
    end

endmodule

// File: doc/hsv_core_mem_io.md
Name: hsv_core_mem_io

Overview:
- Slow-path back end of the memory execution unit.
- Consumes one `read_write_t` at a time from the address/strobe-generation stage and runs a single AXI4 transaction: one beat, never pipelined, never forwarded.
- Produces a `commit_data_t` for the commit stage.
- Used for I/O space (`address_is_memory()` false). It also executes any access routed to it regardless of `is_memory`.

Parameters:
- `LoadMisalignCause`, 4, trap_cause for unaligned load.
- `LoadFaultCause`, 5, trap_cause for read AXI error.
- `StoreMisalignCause`, 6, trap_cause for unaligned store.
- `StoreFaultCause`, 7, trap_cause for write AXI error.

Ports:
- `clk_core`  in  1  core clock
- `rst_core`  in  1  synchronous reset, active-high
- `flush_req`  in  1  pipeline flush from commit
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when in_valid&in_ready
- `in`  in  $bits(read_write_t)  request
- `out_valid`  out  1  result valid
- `out_ready`  in  1  commit accepts result
- `out`  out  $bits(commit_data_t)  result
- `m_arvalid`/`m_arready`  out/in  1  read address handshake
- `m_araddr`  out  32  read address
- `m_arsize`  out  3  axi_size_t
- `m_rvalid`/`m_rready`  in/out  1  read data handshake
- `m_rdata`  in  32  read data
- `m_rresp`  in  2  axi_resp_t
- `m_awvalid`/`m_awready`  out/in  1  write address handshake
- `m_awaddr`  out  32  write address
- `m_awsize`  out  3  axi_size_t
- `m_wvalid`/`m_wready`  out/in  1  write data handshake
- `m_wdata`  out  32  write data
- `m_wstrb`  out  4  write strobes
- `m_bvalid`/`m_bready`  in/out  1  write response handshake
- `m_bresp`  in  2  axi_resp_t

Behaviour:
- Fixed AXI fields: len=0, burst INCR, wlast=1 (internal constants, not ports).
- Size mapping: BYTE→AXI_SIZE_1, HALF→AXI_SIZE_2, WORD→AXI_SIZE_4. Address is `in.address` unmodified.
- States: IDLE, AR, R, AW_W, B, OUT. Reset: state IDLE; all *valid/*ready outputs 0; discard flag 0.
- `in_ready` = (state==IDLE) & ~flush_req. The request is latched on acceptance.
- IDLE exits, one cycle after acceptance:
  - unaligned_address=1 → OUT, no bus activity.
  - read → AR.
  - write → AW_W.
- AR: `m_arvalid`=1, held stable until arready → R.
- R: `m_rready`=1; on rvalid capture rdata/rresp → OUT.
- AW_W: `m_awvalid` and `m_wvalid` both rise on entry.
  - Each drops independently after its own handshake; handshakes may occur in either order or the same cycle.
  - Both done → B.
- B: `m_bready`=1; on bvalid capture bresp → OUT.
- OUT: `out_valid`=1; `out` stable while ~out_ready; on out_ready → IDLE.
- Latency: accept at cycle N → AR/AW valid at N+1. Final response handshake at M → out_valid at M+1. Unaligned: out_valid at N+1.
- Read result: shift rdata right by read_shift*8, then:
  - BYTE: bits[7:0], sign- or zero-extended per `sign_extend`.
  - HALF: bits[15:0], same rule.
  - WORD: unchanged.
- `out` fields:
  - common = `mem_data.common`.
  - next_pc = `common.pc_increment`.
  - jump=0.
  - trap = unaligned | is_axi_error(resp).
  - action = trap ? COMMIT_EXCEPTION : COMMIT_NEXT.
  - trap_cause: misalign cause by direction if unaligned, else fault cause by direction.
  - trap_value = address.
  - writeback = read & ~trap.
  - result = read value, or 0 for writes and traps.
- Flush:
  - In IDLE or OUT: go to IDLE next cycle, out_valid drops.
  - In AR/R/AW_W/B: set discard. The AXI transaction runs to completion, because handshakes are never abandoned.
  - When the final response arrives with discard set → IDLE without out_valid; discard clears.
  - flush_req in the same cycle as in_valid: no acceptance (in_ready=0).
- AXI errors never stall; exactly one response is consumed per transaction.
- Reset mid-transaction → IDLE immediately. The external interconnect is reset by the same `rst_core`.

Test Plan:
- lb, address 0x4000_0003, read_shift=3, sign_extend=1, rdata 0x80AB_CDEF, rresp OKAY → arsize=0, araddr 0x4000_0003, result 0xFFFF_FF80, writeback=1, action COMMIT_NEXT, out_valid one cycle after rvalid.
- sw to 0x4000_0010, data 0xDEAD_BEEF, strobe 0xF; wready immediate, awready after 3 cycles → wvalid high 1 cycle, awvalid high 4 cycles, bready only in B; bresp OKAY → writeback=0, trap=0.
- lhu, rresp SLVERR → action COMMIT_EXCEPTION, trap_cause 5, trap_value=address, writeback=0. Same case with bresp DECERR on a store → cause 7.
- Unaligned lw at 0x4000_0002 → arvalid never asserts; out_valid at N+1, trap_cause 4. Unaligned sh → cause 6.
- flush_req asserted during R with rvalid 4 cycles later → rready held until handshake, no out_valid, in_ready=1 the cycle after rvalid.
- out_ready low 5 cycles in OUT → `out` bit-stable and in_ready=0; rst_core pulse during AW_W → all valids 0 next cycle, state IDLE.
